// File: rtl/car_sim_pkg.sv
// Shared definitions for the vehicle simulation blocks: SPI ADC responder
// state encoding, command/data widths and the channel codes the dashboard
// ADC master uses.
package car_sim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CMD,
        NULL,
        DATA,
        LSBF,
        DONE
    } spi_resp_state_t;

    localparam int ADC_CMD_BITS  = 3;
    localparam int ADC_DATA_BITS = 12;

    localparam logic [1:0] ADC_CH_ACCEL = 2'b10;
    localparam logic [1:0] ADC_CH_CDS   = 2'b11;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the CLK domain: two-flop synchronizer
// per pin, then a registered edge detect on SCK and CS_n. Edge pulses appear
// three CLK after the pin changes; mosi_s is aligned with sck_rise.
module spi_pin_sync (
    input  logic CLK,
    input  logic global_safe_rst,
    input  logic spi_sck,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s,
    output logic cs_n_s
);

    logic [2:0] w_pins;
    logic [2:0] w_sync;
    logic [1:0] r_prev;
    logic       r_sck_rise;
    logic       r_sck_fall;
    logic       r_cs_fall;
    logic       r_cs_rise;
    logic       r_mosi;

    assign w_pins = {spi_mosi, spi_cs_n, spi_sck};

    // Synchronizers reset low so a CS held low through reset never looks
    // like a falling edge afterwards.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic r_s1;
            logic r_s2;
            // Two-flop synchronizer for one pin
            always_ff @(posedge CLK or posedge global_safe_rst) begin
                if (global_safe_rst) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                end else begin
                    r_s1 <= w_pins[gi];
                    r_s2 <= r_s1;
                end
            end
            assign w_sync[gi] = r_s2;
        end
    endgenerate

    // Registered edge detect for SCK/CS and MOSI aligned to the SCK edges
    always_ff @(posedge CLK or posedge global_safe_rst) begin
        if (global_safe_rst) begin
            r_prev     <= 2'b00;
            r_sck_rise <= 1'b0;
            r_sck_fall <= 1'b0;
            r_cs_fall  <= 1'b0;
            r_cs_rise  <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_prev     <= w_sync[1:0];
            r_sck_rise <= w_sync[0] & ~r_prev[0];
            r_sck_fall <= ~w_sync[0] & r_prev[0];
            r_cs_rise  <= w_sync[1] & ~r_prev[1];
            r_cs_fall  <= ~w_sync[1] & r_prev[1];
            r_mosi     <= w_sync[2];
        end
    end

    assign sck_rise = r_sck_rise;
    assign sck_fall = r_sck_fall;
    assign cs_fall  = r_cs_fall;
    assign cs_rise  = r_cs_rise;
    assign mosi_s   = r_mosi;
    assign cs_n_s   = w_sync[1];

endmodule

// File: rtl/spi_adc_responder.sv
// Emulates a two-channel MCP3202-style serial ADC: decodes the command
// frame from the oversampled SPI pins and shifts out the selected (or
// clamped differential) channel value, optionally followed by the
// LSB-first repeat.
module spi_adc_responder
    import car_sim_pkg::*;
#(
    parameter int DATA_BITS = ADC_DATA_BITS,
    parameter int CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 global_safe_rst,
    input  logic                 spi_sck,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    input  logic [DATA_BITS-1:0] ch0_value,
    input  logic [DATA_BITS-1:0] ch1_value,
    output logic                 frame_done,
    output logic [1:0]           frame_ch,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     frame_count
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);
    localparam logic [1:0] CMD_LAST = 2'(ADC_CMD_BITS - 1);

    logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_mosi_s, w_cs_n_s;

    spi_pin_sync u_pin_sync (
        .CLK             (CLK),
        .global_safe_rst (global_safe_rst),
        .spi_sck         (spi_sck),
        .spi_cs_n        (spi_cs_n),
        .spi_mosi        (spi_mosi),
        .sck_rise        (w_sck_rise),
        .sck_fall        (w_sck_fall),
        .cs_fall         (w_cs_fall),
        .cs_rise         (w_cs_rise),
        .mosi_s          (w_mosi_s),
        .cs_n_s          (w_cs_n_s)
    );

    spi_resp_state_t       r_state, w_state_next;
    logic                  r_miso, w_miso_next;
    logic                  r_oe, w_oe_next;
    logic                  r_done, w_done_next;
    logic                  r_err, w_err_next;
    logic [1:0]            r_ch, w_ch_next;
    logic [CNT_W-1:0]      r_count, w_count_next;
    logic                  r_armed, w_armed_next;
    logic                  r_sgl, w_sgl_next;
    logic                  r_odd, w_odd_next;
    logic                  r_msbf, w_msbf_next;
    logic [1:0]            r_bit_cnt, w_bit_cnt_next;
    logic [IDX_W-1:0]      r_idx, w_idx_next;
    logic [DATA_BITS-1:0]  r_shift, w_shift_next;

    // Differences carry one extra bit; a set MSB is the borrow that clamps to 0
    logic [DATA_BITS:0]    w_diff_01, w_diff_10;
    logic [DATA_BITS-1:0]  w_result;
    logic [IDX_W-1:0]      w_idx_dn, w_idx_up;

    assign w_diff_10 = {1'b0, ch0_value} - {1'b0, ch1_value};
    assign w_diff_01 = {1'b0, ch1_value} - {1'b0, ch0_value};
    assign w_idx_dn  = r_idx - IDX_W'(1);
    assign w_idx_up  = r_idx + IDX_W'(1);

    // Conversion result for the SGL/ODD bits already received
    always_comb begin
        w_result = '0;
        case ({r_sgl, r_odd})
            ADC_CH_ACCEL: w_result = ch0_value;
            ADC_CH_CDS:   w_result = ch1_value;
            2'b00:        w_result = w_diff_10[DATA_BITS] ? '0 : w_diff_10[DATA_BITS-1:0];
            default:      w_result = w_diff_01[DATA_BITS] ? '0 : w_diff_01[DATA_BITS-1:0];
        endcase
    end

    // Next-state and output decode; a CS rise outranks any SCK edge
    always_comb begin
        w_state_next   = r_state;
        w_miso_next    = r_miso;
        w_oe_next      = r_oe;
        w_done_next    = 1'b0;
        w_err_next     = 1'b0;
        w_ch_next      = r_ch;
        w_count_next   = r_count;
        w_armed_next   = r_armed | w_cs_n_s;
        w_sgl_next     = r_sgl;
        w_odd_next     = r_odd;
        w_msbf_next    = r_msbf;
        w_bit_cnt_next = r_bit_cnt;
        w_idx_next     = r_idx;
        w_shift_next   = r_shift;

        if (r_state == IDLE) begin
            w_oe_next   = 1'b0;
            w_miso_next = 1'b0;
            if (w_cs_fall && r_armed) begin
                w_state_next = START;
                w_oe_next    = 1'b1;
            end
        end else if (w_cs_rise) begin
            w_err_next   = (r_state != DONE);
            w_state_next = IDLE;
            w_oe_next    = 1'b0;
            w_miso_next  = 1'b0;
        end else begin
            case (r_state)
                START: begin
                    if (w_sck_rise && w_mosi_s) begin
                        w_state_next   = CMD;
                        w_bit_cnt_next = 2'd0;
                    end
                end
                CMD: begin
                    if (w_sck_rise) begin
                        w_bit_cnt_next = r_bit_cnt + 2'd1;
                        if (r_bit_cnt == 2'd0) begin
                            w_sgl_next = w_mosi_s;
                        end else if (r_bit_cnt == 2'd1) begin
                            w_odd_next = w_mosi_s;
                        end else if (r_bit_cnt == CMD_LAST) begin
                            w_msbf_next    = w_mosi_s;
                            w_shift_next   = w_result;
                            w_bit_cnt_next = 2'd0;
                            w_state_next   = NULL;
                        end
                    end
                end
                NULL: begin
                    if (w_sck_fall) begin
                        if (r_bit_cnt == 2'd0) begin
                            w_miso_next    = 1'b0;
                            w_bit_cnt_next = 2'd1;
                        end else begin
                            w_miso_next  = r_shift[IDX_MAX];
                            w_idx_next   = IDX_MAX;
                            w_state_next = DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_sck_fall && r_idx != '0) begin
                        w_idx_next  = w_idx_dn;
                        w_miso_next = r_shift[w_idx_dn];
                    end else if (w_sck_rise && r_idx == '0) begin
                        if (r_msbf) begin
                            w_state_next = DONE;
                            w_miso_next  = 1'b0;
                            w_done_next  = 1'b1;
                            w_ch_next    = {r_sgl, r_odd};
                            w_count_next = r_count + CNT_W'(1);
                        end else begin
                            w_state_next = LSBF;
                        end
                    end
                end
                LSBF: begin
                    if (w_sck_fall && r_idx != IDX_MAX) begin
                        w_idx_next  = w_idx_up;
                        w_miso_next = r_shift[w_idx_up];
                    end else if (w_sck_rise && r_idx == IDX_MAX) begin
                        w_state_next = DONE;
                        w_miso_next  = 1'b0;
                        w_done_next  = 1'b1;
                        w_ch_next    = {r_sgl, r_odd};
                        w_count_next = r_count + CNT_W'(1);
                    end
                end
                DONE: begin
                    w_miso_next = 1'b0;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge CLK or posedge global_safe_rst) begin
        if (global_safe_rst) begin
            r_state   <= IDLE;
            r_miso    <= 1'b0;
            r_oe      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ch      <= 2'b00;
            r_count   <= '0;
            r_armed   <= 1'b0;
            r_sgl     <= 1'b0;
            r_odd     <= 1'b0;
            r_msbf    <= 1'b0;
            r_bit_cnt <= 2'd0;
            r_idx     <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_miso    <= w_miso_next;
            r_oe      <= w_oe_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
            r_ch      <= w_ch_next;
            r_count   <= w_count_next;
            r_armed   <= w_armed_next;
            r_sgl     <= w_sgl_next;
            r_odd     <= w_odd_next;
            r_msbf    <= w_msbf_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_idx     <= w_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_oe;
    assign frame_done  = r_done;
    assign frame_err   = r_err;
    assign frame_ch    = r_ch;
    assign frame_count = r_count;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: a bit-banged SPI master runs table-driven
// frames; frame completions are checked against a scoreboard queue, and
// hand-written sequences cover abort, reset mid-frame and counter wrap.
module tb_spi_adc_responder;

    localparam int DB = 12;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          global_safe_rst = 1'b1;
    logic          spi_sck = 1'b0;
    logic          spi_cs_n = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic          spi_miso_oe;
    logic [DB-1:0] ch0_value = '0;
    logic [DB-1:0] ch1_value = '0;
    logic          frame_done;
    logic [1:0]    frame_ch;
    logic          frame_err;
    logic [CW-1:0] frame_count;

    always #5 CLK = ~CLK;

    spi_adc_responder #(.DATA_BITS(DB), .CNT_W(CW)) dut (
        .CLK             (CLK),
        .global_safe_rst (global_safe_rst),
        .spi_sck         (spi_sck),
        .spi_cs_n        (spi_cs_n),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso),
        .spi_miso_oe     (spi_miso_oe),
        .ch0_value       (ch0_value),
        .ch1_value       (ch1_value),
        .frame_done      (frame_done),
        .frame_ch        (frame_ch),
        .frame_err       (frame_err),
        .frame_count     (frame_count)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [1:0]    ch;
        logic [CW-1:0] cnt;
    } sb_t;
    sb_t sb_q[$];
    logic [CW-1:0] exp_count = '0;

    typedef struct {
        logic [DB-1:0] c0;
        logic [DB-1:0] c1;
        logic          s;
        logic          o;
        logic          m;
        int            lead;
        logic [DB-1:0] r;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Scoreboard side: every frame_done pops the frame expected next
    always @(negedge CLK) begin
        if (frame_err) err_cnt++;
        if (frame_done) begin
            sb_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("frame_ch", 32'(frame_ch), 32'(e.ch));
                check("frame_count", 32'(frame_count), 32'(e.cnt));
            end
        end
    end

    function automatic logic [DB-1:0] model(input logic s, input logic o,
                                            input logic [DB-1:0] a, input logic [DB-1:0] b);
        int d;
        logic [DB-1:0] r;
        case ({s, o})
            2'b10: r = a;
            2'b11: r = b;
            2'b00: begin d = int'(a) - int'(b); r = (d < 0) ? '0 : d[DB-1:0]; end
            default: begin d = int'(b) - int'(a); r = (d < 0) ? '0 : d[DB-1:0]; end
        endcase
        return r;
    endfunction

    // One SCK period, mode 0: MOSI set while low, MISO sampled at the rise
    task automatic send_bit(input logic b, output logic q);
        spi_mosi = b;
        tick(8);
        spi_sck = 1'b1;
        q = spi_miso;
        tick(8);
        spi_sck = 1'b0;
    endtask

    // Full frame; abort_after >= 0 raises CS after that many data-phase rises
    task automatic run_frame(input vec_t v, input int abort_after);
        logic [31:0] rx, ex;
        logic q;
        int nb, d0, e0;
        sb_t e;
        rx = '0;
        ex = '0;
        d0 = done_cnt;
        e0 = err_cnt;
        ch0_value = v.c0;
        ch1_value = v.c1;
        if (abort_after < 0) begin
            exp_count = exp_count + 1'b1;
            e.ch  = {v.s, v.o};
            e.cnt = exp_count;
            sb_q.push_back(e);
        end
        spi_cs_n = 1'b0;
        tick(3);
        check("oe_rise_early", 32'(spi_miso_oe), 32'd0);
        tick(1);
        check("oe_rise", 32'(spi_miso_oe), 32'd1);
        tick(4);
        for (int i = 0; i < v.lead; i++) send_bit(1'b0, q);
        send_bit(1'b1, q);
        send_bit(v.s, q);
        send_bit(v.o, q);
        send_bit(v.m, q);
        // Inputs change after the snapshot; the frame must not follow them
        ch0_value = ~v.c0;
        ch1_value = ~v.c1;
        nb = v.m ? DB + 1 : 2 * DB;
        for (int i = 0; i < nb; i++) begin
            if (i == abort_after) break;
            send_bit(1'b0, q);
            rx = {rx[30:0], q};
        end
        tick(6);
        spi_cs_n = 1'b1;
        if (abort_after >= 0) begin
            tick(3);
            check("oe_fall_early", 32'(spi_miso_oe), 32'd1);
            tick(1);
            check("oe_fall", 32'(spi_miso_oe), 32'd0);
            tick(8);
            check("abort_err", 32'(err_cnt - e0), 32'd1);
            check("abort_no_done", 32'(done_cnt - d0), 32'd0);
            check("abort_count", 32'(frame_count), 32'(exp_count));
            $display("abort  ch=%b%b after=%0d rises count=%0d", v.s, v.o, abort_after, frame_count);
        end else begin
            tick(12);
            ex = {ex[30:0], 1'b0};
            for (int i = DB - 1; i >= 0; i--) ex = {ex[30:0], v.r[i]};
            if (!v.m) for (int i = 1; i < DB; i++) ex = {ex[30:0], v.r[i]};
            check("miso_data", rx, ex);
            check("done_pulse", 32'(done_cnt - d0), 32'd1);
            check("no_err", 32'(err_cnt - e0), 32'd0);
            check("oe_idle", 32'(spi_miso_oe), 32'd0);
            $display("frame  ch=%b%b msbf=%b rx=%h exp=%h count=%0d", v.s, v.o, v.m, rx, ex, frame_count);
        end
    endtask

    initial begin
        vec_t v;
        logic q;
        int d0, e0;

        vecs[0] = '{12'hA5C, 12'h000, 1'b1, 1'b0, 1'b1, 0, 12'hA5C};
        vecs[1] = '{12'h100, 12'h180, 1'b0, 1'b1, 1'b1, 1, 12'h080};
        vecs[2] = '{12'h100, 12'h180, 1'b0, 1'b0, 1'b1, 0, 12'h000};
        vecs[3] = '{12'h000, 12'h3C1, 1'b1, 1'b1, 1'b0, 2, 12'h3C1};
        vecs[4] = '{12'hFFF, 12'h001, 1'b0, 1'b0, 1'b1, 0, 12'hFFE};
        vecs[5] = '{12'h000, 12'hFFF, 1'b0, 1'b1, 1'b0, 0, 12'hFFF};
        vecs[6] = '{12'h800, 12'h7FF, 1'b0, 1'b0, 1'b1, 3, 12'h001};
        vecs[7] = '{12'h555, 12'hAAA, 1'b1, 1'b1, 1'b1, 0, 12'hAAA};

        tick(3);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_ch", 32'(frame_ch), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        global_safe_rst = 1'b0;
        tick(10);

        for (int i = 0; i < 8; i++) run_frame(vecs[i], -1);

        // Abort after B5 has been sampled, then a clean frame
        run_frame(vecs[0], 8);
        run_frame(vecs[7], -1);

        // Reset in the middle of the data phase with CS held low
        d0 = done_cnt;
        e0 = err_cnt;
        ch0_value = 12'hFFF;
        spi_cs_n = 1'b0;
        tick(8);
        send_bit(1'b1, q);
        send_bit(1'b1, q);
        send_bit(1'b0, q);
        send_bit(1'b1, q);
        for (int i = 0; i < 3; i++) send_bit(1'b0, q);
        check("pre_rst_miso", 32'(spi_miso), 32'd1);
        global_safe_rst = 1'b1;
        #1;
        check("midrst_miso", 32'(spi_miso), 32'd0);
        check("midrst_oe", 32'(spi_miso_oe), 32'd0);
        tick(2);
        global_safe_rst = 1'b0;
        exp_count = '0;
        for (int i = 0; i < 10; i++) send_bit(1'b0, q);
        check("midrst_oe_tail", 32'(spi_miso_oe), 32'd0);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
        check("midrst_count", 32'(frame_count), 32'd0);
        $display("reset  mid-frame count=%0d oe=%b", frame_count, spi_miso_oe);
        tick(6);
        spi_cs_n = 1'b1;
        tick(10);
        run_frame(vecs[3], -1);

        // Run the narrow counter up to its top, then one more frame wraps it
        while (exp_count != {CW{1'b1}}) begin
            v.c0 = 12'($urandom_range(0, 4095));
            v.c1 = 12'($urandom_range(0, 4095));
            v.s = 1'($urandom_range(0, 1));
            v.o = 1'($urandom_range(0, 1));
            v.m = 1'b1;
            v.lead = 0;
            v.r = model(v.s, v.o, v.c0, v.c1);
            run_frame(v, -1);
        end
        run_frame(vecs[4], -1);
        check("wrap_count", 32'(frame_count), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

Synthesizable SPI responder that emulates the two-channel 12-bit serial ADC read by the dashboard's SPI ADC master, which polls the accelerator (CH0) and CdS (CH1) channels. It answers MCP3202-style command frames from parallel channel values, so the ADC master and the whole vehicle pipeline run hardware-in-the-loop on a second board or in system simulation without the physical ADC. It oversamples the SPI pins in the CLK domain, decodes the command, and shifts the selected conversion result out on MISO.

## Interface
- `DATA_BITS`, default 12: conversion width shifted per frame.
- `CNT_W`, default 16: width of `frame_count`.
- `CLK` input, 1 bit: system clock.
- `global_safe_rst` input, 1 bit: asynchronous, active-high reset.
- `spi_sck` input, 1 bit: serial clock from the master, mode 0, idle low.
- `spi_cs_n` input, 1 bit: chip select, active low.
- `spi_mosi` input, 1 bit: command data from the master.
- `spi_miso` output, 1 bit: conversion data to the master.
- `spi_miso_oe` output, 1 bit: MISO drive enable; the pad is tri-stated when this is 0.
- `ch0_value` input, `DATA_BITS` wide: emulated CH0 result.
- `ch1_value` input, `DATA_BITS` wide: emulated CH1 result.
- `frame_done` output, 1 bit: one-CLK pulse when a frame completes.
- `frame_ch` output, 2 bits: the `{SGL, ODD}` of the last completed frame.
- `frame_err` output, 1 bit: one-CLK pulse when a frame is aborted.
- `frame_count` output, `CNT_W` wide: number of completed frames; wraps to 0.

## Operation
- **Reset values:** `spi_miso`=0, `spi_miso_oe`=0, `frame_done`=0, `frame_err`=0, `frame_ch`=0, `frame_count`=0, state IDLE, `armed`=0.
- **Arming after reset:** `armed` sets only after `spi_cs_n` has been seen high (synchronized). A reset that lands mid-frame therefore ignores the remainder of that frame.
- **Edge sampling:** MOSI is sampled on SCK rise. MISO changes on SCK fall. SCK edges are ignored while CS is high.
- **States:**
  - **IDLE:** CS high. `oe`=0, `miso`=0. A CS fall with `armed`=1 goes to START and sets `oe`=1.
  - **START:** Leading MOSI zeros are ignored. The first rise that samples MOSI=1 goes to CMD.
  - **CMD:** Three rises sample SGL, ODD and MSBF in that order. On the MSBF rise, snapshot the result into the shift register and go to NULL.
  - **NULL:** The next fall drives the null bit, `miso`=0. The following fall drives B11 and enters DATA.
  - **DATA:** Each fall drives the next bit, MSB first, down to B0. The rise that samples B0 ends the frame if MSBF=1. If MSBF=0, go to LSBF.
  - **LSBF:** Subsequent falls drive B1..B11 (LSB-first repeat, B0 not repeated). The rise sampling B11 ends the frame.
  - **DONE:** `miso`=0 until CS rises, then IDLE.
- **Result selection:**
  - `{SGL,ODD}`=10 gives CH0.
  - 11 gives CH1.
  - 00 gives CH0−CH1, clamped to 0 if negative.
  - 01 gives CH1−CH0, clamped to 0 if negative.
  - Subtraction is done at `DATA_BITS`+1 bits, and the borrow forces 0.
- **Frame end:** Pulse `frame_done`, latch `frame_ch`, and increment `frame_count` modulo 2^`CNT_W`.
- **Abort:** CS rising in START, CMD, NULL, DATA or LSBF pulses `frame_err`, leaves the count unchanged, and returns to IDLE. A CS rise in DONE is normal.
- **CS priority:** A CS rise in the same CLK as an SCK edge is handled as the CS rise; the SCK edge is dropped.
- **Channel value changes:** Changes to `ch*_value` after the snapshot do not affect the frame in flight.

## Timing
- Pins pass through 2-flop synchronizers plus an edge-detect register, so edges are recognised 3 CLK after they arrive at the pin.
- MISO updates 1 CLK after a fall is recognised, i.e. 4 CLK after the pin edge.
- The requirement on the master is SCK high and low phases ≥ 6 CLK each, and CS setup/hold to SCK ≥ 4 CLK.
- `frame_done` is asserted 1 CLK after the final rise is recognised. `frame_count` and `frame_ch` update in that same cycle.
- `spi_miso_oe` rises 1 CLK after CS fall is recognised and falls 1 CLK after CS rise is recognised.

## Structure
- **Shared package `car_sim_pkg`:**
  - the `spi_resp_state_t` enum (IDLE, START, CMD, NULL, DATA, LSBF, DONE);
  - `ADC_CMD_BITS`=3;
  - `ADC_DATA_BITS`=12;
  - channel codes `ADC_CH_ACCEL`=2'b10 and `ADC_CH_CDS`=2'b11.
- **Sub-module `spi_pin_sync`:** 2-flop synchronizer plus edge detect for SCK, CS_n and MOSI. It outputs the level `sck_rise`, `sck_fall`, `cs_fall`, `cs_rise` and `mosi_s`.

## Test plan
- **Basic read:** `ch0_value`=12'hA5C, master sends start,1,0,1 (CH0, MSBF) → MISO null 0 then A5C MSB-first, `frame_done` pulse, `frame_ch`=10, `frame_count`=1.
- **Differential clamp:** `ch0`=12'h100, `ch1`=12'h180.
  - `{SGL,ODD}`=01 → result 12'h080.
  - `{SGL,ODD}`=00 → result 12'h000.
- **LSB-first tail:** MSBF=0, `ch1`=12'h3C1 → 3C1 MSB-first, then B1..B11 = 0,0,0,0,0,1,1,1,1,0,0, `frame_done` on the rise sampling the final bit.
- **Abort:** CS raised after B5 → `frame_err` pulse, no `frame_done`, count unchanged, `oe`=0 within 4 CLK of the pin edge, and the next full frame succeeds.
- **Reset mid-frame:** Assert reset during DATA with CS held low → `miso`=0 and `oe`=0 immediately, remaining SCK ignored. After CS goes high then low, the frame is accepted normally.
- **Wrap:** Preload via 65535 frames, then one more → `frame_count`=0.
